// File: rtl/wb_port_arbiter.sv
// Purpose: round-robin share of the register-file write port between ALU and load writeback,
//          plus a pending-write scoreboard that decode uses to stall on unwritten sources.
// Latency: 1 cycle from accepted request to wr_enable; busy clears the cycle after the strobe.
// Backpressure: never stalls a lone requester; on conflict the loser sees ready=0 and may retry.
//
// Ports:
//   clk, rst                 clock (rising) and async active-low reset
//   alu_valid/ready/rd/data  ALU writeback request (requester 0)
//   ld_valid/ready/rd/data   load writeback request (requester 1)
//   issue_valid/issue_rd     marks a destination register as pending at issue
//   rs1_addr/rs2_addr        decode source registers; rs1_busy/rs2_busy report pending writes
//   wr_addr/wr_data/wr_enable  registered register-file write port
//   busy_vec                 scoreboard contents (debug)
module wb_port_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_enable,
  output logic [NREG-1:0]   busy_vec
);

  // last_grant: 0 = ALU won the most recent conflict, 1 = load won it.
  logic              last_grant;
  logic              conflict;
  logic              xfer;
  logic [ADDR_W-1:0] xfer_rd;
  logic [DATA_W-1:0] xfer_data;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  // Grant depends only on the two valids and last_grant, never on rd/data.
  always_comb begin
    conflict  = alu_valid && ld_valid;
    alu_ready = alu_valid && (!ld_valid || last_grant);
    ld_ready  = ld_valid  && (!alu_valid || !last_grant);
    xfer      = alu_ready || ld_ready;
    xfer_rd   = alu_ready ? alu_rd   : ld_rd;
    xfer_data = alu_ready ? alu_data : ld_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      wr_enable  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      if (conflict) begin
        last_grant <= ld_ready;
      end
      // An x0 destination still handshakes but never strobes the register file.
      wr_enable <= xfer && (xfer_rd != '0);
      if (xfer) begin
        wr_addr <= xfer_rd;
        wr_data <= xfer_data;
      end
    end
  end

  // Clear first, then set, so an issue on the same edge as the writeback of the
  // same register leaves it pending for the newer producer.
  always_comb begin
    busy_d = busy_q;
    if (wr_enable) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // No bypass from wr_enable: the clear shows up when the register file holds the value.
  assign rs1_busy = busy_q[rs1_addr] && (rs1_addr != '0);
  assign rs2_busy = busy_q[rs2_addr] && (rs2_addr != '0);
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clk;
  logic              rst;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_enable;
  logic [NREG-1:0]   busy_vec;

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              av;
    logic [ADDR_W-1:0] ard;
    logic [DATA_W-1:0] adat;
    logic              lv;
    logic [ADDR_W-1:0] lrd;
    logic [DATA_W-1:0] ldat;
    logic              iv;
    logic [ADDR_W-1:0] ird;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              e_ar;
    logic              e_lr;
    logic              e_b1;
    logic              e_b2;
  } vec_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  localparam int NV = 19;
  vec_t vt[NV];
  wr_t  exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference scoreboard state and the write the bench expects on the port right now.
  logic [NREG-1:0]   busy_m;
  logic              cur_en;
  logic [ADDR_W-1:0] cur_addr;

  function automatic vec_t mk(input logic av, input int ard, input int adat,
                              input logic lv, input int lrd, input int ldat,
                              input logic iv, input int ird, input int rs1, input int rs2,
                              input logic e_ar, input logic e_lr, input logic e_b1, input logic e_b2);
    vec_t v;
    v.av = av; v.ard = ADDR_W'(ard); v.adat = DATA_W'(adat);
    v.lv = lv; v.lrd = ADDR_W'(lrd); v.ldat = DATA_W'(ldat);
    v.iv = iv; v.ird = ADDR_W'(ird);
    v.rs1 = ADDR_W'(rs1); v.rs2 = ADDR_W'(rs2);
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_b1 = e_b1; v.e_b2 = e_b2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  // One cycle: drive at negedge, check handshake/busy before the edge,
  // then compare the write port and scoreboard just after the edge.
  task automatic apply(input vec_t v, input string tag);
    wr_t w;
    wr_t got;
    @(negedge clk);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
    ld_valid = v.lv; ld_rd = v.lrd; ld_data = v.ldat;
    issue_valid = v.iv; issue_rd = v.ird;
    rs1_addr = v.rs1; rs2_addr = v.rs2;
    #1;
    chk({tag, " alu_ready"}, DATA_W'(alu_ready), DATA_W'(v.e_ar));
    chk({tag, " ld_ready"}, DATA_W'(ld_ready), DATA_W'(v.e_lr));
    chk({tag, " rs1_busy"}, DATA_W'(rs1_busy), DATA_W'(v.e_b1));
    chk({tag, " rs2_busy"}, DATA_W'(rs2_busy), DATA_W'(v.e_b2));
    if (v.av && v.e_ar)      w = '{en: (v.ard != 0), addr: v.ard, data: v.adat};
    else if (v.lv && v.e_lr) w = '{en: (v.lrd != 0), addr: v.lrd, data: v.ldat};
    else                     w = '{en: 1'b0, addr: '0, data: '0};
    exp_q.push_back(w);
    if (cur_en) busy_m[cur_addr] = 1'b0;
    if (v.iv && v.ird != 0) busy_m[v.ird] = 1'b1;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: queue empty, expected an entry", tag);
    end else begin
      got = exp_q.pop_front();
      chk({tag, " wr_enable"}, DATA_W'(wr_enable), DATA_W'(got.en));
      if (got.en) begin
        chk({tag, " wr_addr"}, DATA_W'(wr_addr), DATA_W'(got.addr));
        chk({tag, " wr_data"}, wr_data, got.data);
      end
      cur_en = got.en;
      cur_addr = got.addr;
    end
    chk({tag, " busy_vec"}, DATA_W'(busy_vec), DATA_W'(busy_m));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    //            av ard adat   lv lrd ldat   iv ird rs1 rs2  ar lr b1 b2
    vt[0]  = mk(1, 3, 'hAA,  0, 0, 0,     0, 0,  0, 0,   1, 0, 0, 0); // post-reset first write
    vt[1]  = mk(0, 0, 0,     0, 0, 0,     1, 7,  7, 0,   0, 0, 0, 0); // issue x7, not yet visible
    vt[2]  = mk(0, 0, 0,     1, 7, 'h77,  0, 0,  7, 0,   0, 1, 1, 0); // x7 busy, load writes x7
    vt[3]  = mk(0, 0, 0,     0, 0, 0,     0, 0,  7, 0,   0, 0, 1, 0); // strobe cycle: still busy
    vt[4]  = mk(0, 0, 0,     0, 0, 0,     0, 0,  7, 0,   0, 0, 0, 0); // clear visible
    vt[5]  = mk(1, 1, 'h11,  1, 2, 'h22,  0, 0,  0, 0,   1, 0, 0, 0); // conflict: ALU first
    vt[6]  = mk(1, 1, 'h11,  1, 2, 'h22,  0, 0,  0, 0,   0, 1, 0, 0);
    vt[7]  = mk(1, 1, 'h11,  1, 2, 'h22,  0, 0,  0, 0,   1, 0, 0, 0);
    vt[8]  = mk(1, 1, 'h11,  1, 2, 'h22,  0, 0,  0, 0,   0, 1, 0, 0);
    vt[9]  = mk(1, 9, 'h99,  0, 0, 0,     1, 9,  0, 9,   1, 0, 0, 0); // issue x9, ALU writes x9
    vt[10] = mk(0, 0, 0,     0, 0, 0,     1, 9,  0, 9,   0, 0, 0, 1); // re-issue x9 on strobe edge
    vt[11] = mk(0, 0, 0,     0, 0, 0,     0, 0,  0, 9,   0, 0, 0, 1); // set won over clear
    vt[12] = mk(1, 0, 'h05,  0, 0, 0,     1, 0,  0, 0,   1, 0, 0, 0); // x0 write and issue
    vt[13] = mk(0, 0, 0,     0, 0, 0,     0, 0,  9, 0,   0, 0, 1, 0); // no strobe for x0
    vt[14] = mk(1, 4, 'h44,  1, 6, 'h66,  0, 0,  0, 0,   1, 0, 0, 0); // last was LD -> ALU
    vt[15] = mk(0, 0, 0,     1, 6, 'h66,  0, 0,  0, 0,   0, 1, 0, 0); // lone LD: no grant update
    vt[16] = mk(1, 4, 'h44,  1, 6, 'h66,  0, 0,  0, 0,   0, 1, 0, 0); // last conflict was ALU -> LD
    vt[17] = mk(1, 4, 'h44,  1, 6, 'h66,  0, 0,  0, 0,   1, 0, 0, 0);
    vt[18] = mk(0, 0, 0,     0, 0, 0,     0, 0,  0, 0,   0, 0, 0, 0);

    busy_m = '0; cur_en = 1'b0; cur_addr = '0;

    // Reset held with a request present: nothing may reach the write port.
    idle_inputs();
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 'hAA;
    @(posedge clk); @(posedge clk); #1;
    chk("reset wr_enable", DATA_W'(wr_enable), '0);
    chk("reset busy_vec", DATA_W'(busy_vec), '0);
    chk("reset wr_addr", DATA_W'(wr_addr), '0);
    chk("reset wr_data", wr_data, '0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(vt[i], $sformatf("v%0d", i));
    end

    // Asynchronous reset right after a transfer of x5.
    apply(mk(1, 5, 'h55, 0, 0, 0, 1, 5, 0, 0, 1, 0, 0, 0), "pre_rst");
    chk("pre_rst busy5", DATA_W'(busy_vec[5]), 'd1);
    #2;
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("async wr_enable", DATA_W'(wr_enable), '0);
    chk("async busy_vec", DATA_W'(busy_vec), '0);
    @(posedge clk); #1;
    chk("in_rst wr_enable", DATA_W'(wr_enable), '0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    busy_m = '0; cur_en = 1'b0; cur_addr = '0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0), "post_rst_idle");
    // last_grant was ALU before reset; reset restores ALU priority on the next conflict.
    apply(mk(1, 8, 'h88, 1, 10, 'hA0, 0, 0, 0, 0, 1, 0, 0, 0), "post_rst_conf");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: ALU (req 0) and load unit (req 1). Arbitration is round-robin and the winning write is registered onto the write port. The block also keeps a 32-entry pending-write scoreboard, set at issue and cleared at writeback. Decode uses it to stall on source registers whose result has not yet been written. Sits between the execute/memory stages and the register file write port.

Parameters:
DATA_W, 64, write data width
ADDR_W, 5, register address width
NREG, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
ld_valid  in  1  load writeback request
ld_ready  out  1  load request accepted this cycle
ld_rd  in  ADDR_W  load destination register
ld_data  in  DATA_W  load result
issue_valid  in  1  instruction with destination issued
issue_rd  in  ADDR_W  issued destination register
rs1_addr  in  ADDR_W  decode source 1
rs2_addr  in  ADDR_W  decode source 2
rs1_busy  out  1  rs1 has a pending write
rs2_busy  out  1  rs2 has a pending write
wr_addr  out  ADDR_W  register file write address
wr_data  out  DATA_W  register file write data
wr_enable  out  1  register file write strobe
busy_vec  out  NREG  scoreboard contents (debug)

Behaviour:
- Reset (rst=0, asynchronous): wr_enable=0, wr_addr=0, wr_data=0, busy_vec=0, last_grant=1 (ALU wins the first conflict). An accepted but not yet written request is discarded.
- Arbitration is combinational and the write port never back-pressures:
  - Only alu_valid set: alu_ready=1.
  - Only ld_valid set: ld_ready=1.
  - Both set: grant the requester that is not last_grant. last_grant updates only on a conflict grant.
  - At most one ready is high per cycle. ready never depends on its own requester's data.
- Handshake: a transfer occurs when valid&&ready. valid may drop without a transfer; there is no hold requirement.
- Latency is 1: a transfer in cycle N gives wr_enable=1 with the registered rd/data in cycle N+1. With no transfer in N, wr_enable=0 in N+1 and wr_addr/wr_data hold their last values.
- Destination x0: the transfer still handshakes, but wr_enable stays 0 in N+1.
- Scoreboard:
  - On clock edge with issue_valid && issue_rd!=0: busy[issue_rd] is set.
  - On clock edge with wr_enable: busy[wr_addr] is cleared.
  - Set and clear of the same register on the same edge: set wins (newer producer).
  - busy[0] is always 0.
- rs1_busy = busy[rs1_addr] && rs1_addr!=0; rs2_busy likewise. Both are combinational from the registered scoreboard, with no forwarding from wr_enable. The clear is visible on the cycle after the write strobe, matching register file update timing.
- Issue to an already-busy register leaves it set (single bit, no count). Decode must not issue a second writer before the first has written back.

Test Plan:
- Reset: hold rst=0 with alu_valid=1 -> wr_enable=0, busy_vec=0. Release rst, alu_rd=3, alu_data=0xAA -> next cycle wr_enable=1, wr_addr=3, wr_data=0xAA.
- Conflict round-robin: both valid for 4 cycles with alu_rd=1 and ld_rd=2 -> grants alternate ALU, LD, ALU, LD. Write port shows rd 1, 2, 1, 2 one cycle later. Exactly one ready high per cycle.
- Scoreboard: issue_rd=7 -> rs1_addr=7 gives rs1_busy=1 from the next cycle. ld write of x7 -> rs1_busy still 1 in the wr_enable cycle and 0 the cycle after.
- Same-edge set/clear: wr_enable for x9 with issue_rd=9 on the same edge -> busy[9]=1 afterwards.
- x0 handling: issue_rd=0 and alu_rd=0 transfer -> alu_ready=1, wr_enable stays 0, busy_vec[0]=0, rs2_addr=0 gives rs2_busy=0.
- Async reset mid-flight: assert rst low between clock edges, just after a transfer of rd=5 -> wr_enable drops immediately, busy_vec=0, no write occurs at the next edge.
